// File: rtl/result_wb_arbiter.sv
// rtl/result_wb_arbiter.sv - round-robin write-back arbiter/sequencer for the BF16 result register
// Optional macro RESULT_WB_FIXED_PRIO_EN selects fixed lowest-index priority (pointer held at 0).
module result_wb_arbiter #(
  parameter int N = 4,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [N-1:0]      req,
  input  logic [16*N-1:0]   req_data,
  input  logic              flush,
  output logic [N-1:0]      gnt,
  output logic              reg_en,
  output logic              reg_clr,
  output logic [15:0]       reg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] out_id_nxt;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  logic            grant;
  int              idx;

  // Scan from the pointer upward, wrapping; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign grant = (state == IDLE) && !flush && win_found;

`ifdef RESULT_WB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_W-1:0] ptr_nxt;

  always_comb begin
    ptr_nxt = ptr;
    if (grant) ptr_nxt = (int'(win_id) == N - 1) ? '0 : win_id + 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) ptr <= '0;
    else     ptr <= ptr_nxt;
  end
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      out_id <= '0;
    end else begin
      state  <= state_nxt;
      out_id <= out_id_nxt;
    end
  end

  // flush wins over both a pending grant and a downstream handshake.
  always_comb begin
    state_nxt  = state;
    out_id_nxt = out_id;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state_nxt  = HOLD;
          out_id_nxt = win_id;
        end
        HOLD: if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    gnt      = '0;
    reg_en   = 1'b0;
    reg_data = '0;
    if (grant) begin
      gnt[win_id] = 1'b1;
      reg_en      = 1'b1;
      reg_data    = req_data[16*int'(win_id) +: 16];
    end
  end

  assign reg_clr   = flush;
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_result_wb_arbiter.sv
// tb/tb_result_wb_arbiter.sv - vector table plus scoreboard bench for result_wb_arbiter
module tb_result_wb_arbiter;

  logic        clk;
  logic        clr;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic        flush;
  logic [3:0]  gnt;
  logic        reg_en;
  logic        reg_clr;
  logic [15:0] reg_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic        busy;

  result_wb_arbiter #(.N(4)) dut (
    .clk(clk), .clr(clr), .req(req), .req_data(req_data), .flush(flush),
    .gnt(gnt), .reg_en(reg_en), .reg_clr(reg_clr), .reg_data(reg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External result register as the systolic array would hold it.
  logic [15:0] res_reg;
  initial res_reg = '0;
  always @(posedge clk) begin
    if (reg_clr)     res_reg <= '0;
    else if (reg_en) res_reg <= reg_data;
  end

  typedef struct {
    logic       clr;
    logic [3:0] req;
    logic       flush;
    logic       rdy;
    logic [3:0] gnt;
    logic       en;
    logic       valid;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  logic [15:0] d [4];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic [3:0] r, input logic f, input logic rd,
                     input logic [3:0] g, input logic e, input logic v, input logic [1:0] i,
                     input logic b);
    vec_t x;
    x.clr = c; x.req = r; x.flush = f; x.rdy = rd;
    x.gnt = g; x.en = e; x.valid = v; x.id = i; x.busy = b;
    vecs.push_back(x);
  endtask

  function automatic logic [15:0] data_of(input logic [3:0] g);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) if (g[k]) r = d[k];
    return r;
  endfunction

  function automatic logic [1:0] id_of(input logic [3:0] g);
    logic [1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) if (g[k]) r = 2'(k);
    return r;
  endfunction

  task automatic sb_pop(input string name);
    sb_t e;
    if (sb.size() == 0) begin
      chk({name, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, " sb_id"}, 32'(out_id), 32'(e.id));
      chk({name, " sb_data"}, 32'(res_reg), 32'(e.data));
    end
  endtask

  initial begin
    d[0] = 16'h4000; d[1] = 16'hBF80; d[2] = 16'h3F80; d[3] = 16'h4049;
    req_data = {d[3], d[2], d[1], d[0]};
    clr = 1'b1; req = '0; flush = 1'b0; out_ready = 1'b0;

    //   clr req     fl rdy   gnt     en v  id b
    add(0, 4'b0100, 0, 0,   4'b0100, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 1,   4'b0000, 0, 1, 2, 1);
    add(0, 4'b0000, 0, 0,   4'b0000, 0, 0, 2, 0);
    add(1, 4'b0000, 0, 0,   4'b0000, 0, 0, 0, 0);
    add(0, 4'b1111, 0, 1,   4'b0001, 1, 0, 0, 0);
    add(0, 4'b1111, 0, 1,   4'b0000, 0, 1, 0, 1);
    add(0, 4'b1111, 0, 1,   4'b0010, 1, 0, 0, 0);
    add(0, 4'b1111, 0, 1,   4'b0000, 0, 1, 1, 1);
    add(0, 4'b1111, 0, 1,   4'b0100, 1, 0, 1, 0);
    add(0, 4'b1111, 0, 1,   4'b0000, 0, 1, 2, 1);
    add(0, 4'b1111, 0, 1,   4'b1000, 1, 0, 2, 0);
    add(0, 4'b1111, 0, 1,   4'b0000, 0, 1, 3, 1);
    add(0, 4'b1111, 0, 1,   4'b0001, 1, 0, 3, 0);
    add(0, 4'b0000, 0, 1,   4'b0000, 0, 1, 0, 1);
    add(1, 4'b0000, 0, 0,   4'b0000, 0, 0, 0, 0);
    add(0, 4'b0011, 0, 0,   4'b0001, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 4'b0010, 0, 0, 4'b0000, 0, 1, 0, 1);
    add(0, 4'b0010, 0, 1,   4'b0000, 0, 1, 0, 1);
    add(0, 4'b0010, 0, 0,   4'b0010, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 1,   4'b0000, 0, 1, 1, 1);
    add(0, 4'b0100, 0, 0,   4'b0100, 1, 0, 1, 0);
    add(0, 4'b0000, 1, 1,   4'b0000, 0, 1, 2, 1);
    add(0, 4'b0000, 0, 0,   4'b0000, 0, 0, 2, 0);
    add(0, 4'b1001, 0, 0,   4'b1000, 1, 0, 2, 0);
    add(0, 4'b0000, 0, 1,   4'b0000, 0, 1, 3, 1);
    add(0, 4'b1111, 1, 0,   4'b0000, 0, 0, 3, 0);
    add(0, 4'b1111, 0, 0,   4'b0001, 1, 0, 3, 0);
    add(0, 4'b0000, 0, 1,   4'b0000, 0, 1, 0, 1);
    add(0, 4'b0100, 0, 0,   4'b0100, 1, 0, 0, 0);

    @(posedge clk); @(posedge clk); #1;
    chk("rst gnt", 32'(gnt), 32'd0);
    chk("rst reg_en", 32'(reg_en), 32'd0);
    chk("rst reg_clr", 32'(reg_clr), 32'd0);
    chk("rst reg_data", 32'(reg_data), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_id", 32'(out_id), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      clr = vecs[i].clr; req = vecs[i].req; flush = vecs[i].flush; out_ready = vecs[i].rdy;
      #3;
      chk($sformatf("r%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("r%0d reg_en", i), 32'(reg_en), 32'(vecs[i].en));
      chk($sformatf("r%0d reg_clr", i), 32'(reg_clr), 32'(vecs[i].flush));
      chk($sformatf("r%0d reg_data", i), 32'(reg_data), 32'(data_of(vecs[i].gnt)));
      chk($sformatf("r%0d out_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      chk($sformatf("r%0d out_id", i), 32'(out_id), 32'(vecs[i].id));
      chk($sformatf("r%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      if (vecs[i].clr || vecs[i].flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) sb_pop($sformatf("r%0d", i));
        if (vecs[i].gnt != 4'b0000) begin
          sb_t e;
          e.id = id_of(vecs[i].gnt);
          e.data = data_of(vecs[i].gnt);
          sb.push_back(e);
        end
      end
    end

    // Asynchronous clr mid-HOLD, released between edges, then a grant with the pointer back at 0.
    @(posedge clk); #1;
    req = '0; out_ready = 1'b0;
    chk("aclr pre valid", 32'(out_valid), 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("aclr valid", 32'(out_valid), 32'd0);
    chk("aclr busy", 32'(busy), 32'd0);
    chk("aclr out_id", 32'(out_id), 32'd0);
    sb.delete();
    #2 clr = 1'b0; req = 4'b1000;
    #1;
    chk("aclr gnt", 32'(gnt), 32'b1000);
    chk("aclr reg_data", 32'(reg_data), 32'(d[3]));
    begin
      sb_t e;
      e.id = 2'd3; e.data = d[3];
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req = '0; out_ready = 1'b1;
    #2;
    chk("aclr hold valid", 32'(out_valid), 32'd1);
    chk("aclr hold id", 32'(out_id), 32'd3);
    if (out_valid && out_ready) sb_pop("aclr");
    @(posedge clk); #1;
    chk("final idle", 32'(busy), 32'd0);
    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_wb_arbiter.md
# result_wb_arbiter

Write-back arbiter and sequencer for the 16-bit BFLOAT16 result register of the systolic array. It collects finished products from N processing-element requesters and grants one at a time (round-robin). It drives the result register's synchronous clear/enable/data inputs and presents each captured result downstream with a valid/ready handshake. It also carries the requester's index so the consumer knows which PE produced the value.

## Interface
- N, default 4: number of requesters, legal 2..16.
- ID_W, default $clog2(N): width of requester index (derived, not overridden).
- clk  input  1: single clock, all state on rising edge.
- clr  input  1: asynchronous, active-high reset.
- req  input  N: per-requester request; held high with its data until granted.
- req_data  input  16*N: packed results, requester i at bits [16*i+15:16*i].
- flush  input  1: synchronous abort/clear of the write-back path.
- gnt  output  N: one-hot grant pulse, one cycle, marks acceptance of req_data.
- reg_en  output  1: enable to result register (combinational from state/req).
- reg_clr  output  1: synchronous clear to result register (combinational = flush).
- reg_data  output  16: muxed winner data to result register input.
- out_valid  output  1: registered result (held in result register) is valid downstream.
- out_ready  input  1: downstream accepts result when high with out_valid.
- out_id  output  ID_W: index of requester whose result is in the register.
- busy  output  1: high in any state other than IDLE.

## Operation
- States: IDLE, HOLD. Reset: state=IDLE, rr pointer=0, out_id=0, out_valid=0; gnt, reg_en, reg_clr, reg_data all 0.
- IDLE, flush=0, any req: winner = first set req at or above pointer, wrapping modulo N. Same cycle: gnt[winner]=1, reg_en=1, reg_data=req_data[winner]. Next: state=HOLD, out_id=winner, pointer=(winner+1) mod N.
- IDLE, no req: all outputs 0, stay IDLE.
- HOLD: out_valid=1, gnt=0, reg_en=0. On out_ready=1 -> IDLE (no grant in that cycle; one bubble).
- flush=1, any state: reg_clr=1, gnt=0, reg_en=0. Next state=IDLE, out_valid=0. The pointer and out_id are unchanged. flush has priority over req and out_ready.
- reg_data = 0 whenever no grant is issued, so no X values reach the register.
- Only one grant per result; requesters not granted keep req asserted, no starvation (round-robin bound: N results).
- out_valid is never lowered without out_ready or flush.

## Timing
- Grant-to-valid latency: 1 cycle (register captures at the grant edge, out_valid high the next cycle).
- Peak throughput: one result per 2 cycles with out_ready tied high.
- out_valid, out_id, and state are registered. gnt, reg_en, reg_clr, and reg_data are combinational from state, req, and flush.
- clr asserted mid-HOLD: immediate return to IDLE, out_valid=0, pointer=0. The result register itself is not cleared by clr; the next grant or flush overwrites it.
- clr deasserted: first grant possible in the first clock edge after release.

## Configuration
- RESULT_WB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, pointer logic removed (pointer reads as 0).
- Not defined: round-robin as above.

## Test plan
- Reset then single requester: req=4'b0100, data2=16'h3F80 → gnt=4'b0100 for one cycle, reg_en=1, next cycle out_valid=1, out_id=2; out_ready=1 → IDLE.
- All four req held, out_ready=1: grants 0,1,2,3,0 on cycles 0,2,4,6,8. With RESULT_WB_FIXED_PRIO_EN, grants are 0 only until req0 drops.
- Backpressure: out_ready=0 for 5 cycles in HOLD → out_valid stays 1, no gnt, req1 stays pending; out_ready=1 → next grant two cycles later.
- Flush in HOLD with out_ready=1 same cycle → reg_clr=1, out_valid=0 next cycle, no handshake counted, pointer unchanged.
- Flush in IDLE with req=4'b1111 → no gnt, reg_en=0, reg_clr=1.
- Async clr mid-HOLD (asserted off clock edge) → out_valid drops immediately, after release req=4'b1000 with pointer 0 → gnt=4'b1000, out_id=3.
